z180_mem_ctrl: RTL

Parametrised memory/IO glue controller between the Z8S180 bus and the boot ROM/SRAM, clocked by hwclk.
- Synchronises CPU strobes; decodes a sizeable boot-ROM overlay that software can switch off via an I/O port.
- Generates registered SRAM ce_n/oe_n/we_n and inserts a programmable number of wait states via wait_n.
- Snoops a configurable memory address into an LED register.
- Replaces the purely combinational decode in top; top keeps the d tri-state and ROM instance.

---
 rtl/z180_bus_pkg.sv | 16 +
 rtl/z180_mem_ctrl_sync2.sv | 23 ++
 rtl/z180_mem_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/z180_bus_pkg.sv
// Shared definitions for the Z8S180 memory/IO glue: FSM encoding, default decode constants.
// Purely declarative; no logic or timing of its own.
package z180_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_RECOVER = 2'd3
  } mem_state_t;

  localparam int          SYNC_STAGES     = 2;
  localparam logic [7:0]  DEF_ROMDIS_PORT = 8'h3f;
  localparam logic [19:0] DEF_LED_ADDR    = 20'h0ffff;

endpackage

// File: rtl/z180_mem_ctrl_sync2.sv
// Two-flop synchroniser for one asynchronous CPU strobe, with a selectable reset value.
// Latency: SYNC_STAGES hwclk edges from input change to o_q; no flow control.
module sync2
  import z180_bus_pkg::*;
#(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_chain <= {SYNC_STAGES{RST_VAL}};
    else       r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/z180_mem_ctrl.sv
// Z8S180 bus glue: boot-ROM overlay decode, registered SRAM strobes, wait-state insertion, LED snoop.
// Strobes assert SYNC_STAGES+1+WAIT_STATES edges after mreq_n falls; the CPU is stalled via wait_n only.
module z180_mem_ctrl
  import z180_bus_pkg::*;
#(
  parameter int          ROM_AW      = 9,
  parameter int          WAIT_STATES = 1,
  parameter logic [19:0] LED_ADDR    = DEF_LED_ADDR,
  parameter logic [7:0]  ROMDIS_PORT = DEF_ROMDIS_PORT
) (
  input  logic              hwclk,
  input  logic              reset,
  input  logic [19:0]       a,
  input  logic [7:0]        d_in,
  input  logic              mreq_n,
  input  logic              iorq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic              m1_n,
  output logic              rom_oe,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              ce_n,
  output logic              oe_n,
  output logic              we_n,
  output logic              wait_n,
  output logic [7:0]        led,
  output logic              rom_en
);

  localparam logic [19:0] ROM_TOP = 20'(2 ** ROM_AW);
  localparam logic [3:0]  WS      = 4'(WAIT_STATES);

  logic w_mreq_s, w_iorq_s, w_rd_s, w_wr_s;

  sync2 #(.RST_VAL(1'b1)) u_sync_mreq (.i_clk(hwclk), .i_rst(reset), .i_d(mreq_n), .o_q(w_mreq_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_iorq (.i_clk(hwclk), .i_rst(reset), .i_d(iorq_n), .o_q(w_iorq_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_rd   (.i_clk(hwclk), .i_rst(reset), .i_d(rd_n),   .o_q(w_rd_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_wr   (.i_clk(hwclk), .i_rst(reset), .i_d(wr_n),   .o_q(w_wr_s));

  mem_state_t r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_rom_cyc, w_rom_cyc_nxt;
  logic       r_rom_en, w_rom_en_nxt;
  logic [7:0] r_led, w_led_nxt;
  logic       r_ce_n, r_oe_n, r_we_n, r_rom_oe;
  logic       w_ce_n_nxt, w_oe_n_nxt, w_we_n_nxt, w_rom_oe_nxt;
  logic       w_rom_hit;

  // Full 20-bit compare so addresses that alias the window above it never select ROM.
  assign w_rom_hit = (a < ROM_TOP);

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_rom_cyc <= 1'b0;
      r_rom_en  <= 1'b1;
      r_led     <= 8'h00;
      r_ce_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_rom_oe  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rom_cyc <= w_rom_cyc_nxt;
      r_rom_en  <= w_rom_en_nxt;
      r_led     <= w_led_nxt;
      r_ce_n    <= w_ce_n_nxt;
      r_oe_n    <= w_oe_n_nxt;
      r_we_n    <= w_we_n_nxt;
      r_rom_oe  <= w_rom_oe_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_rom_cyc_nxt = r_rom_cyc;
    w_rom_en_nxt  = r_rom_en;
    w_led_nxt     = r_led;
    w_ce_n_nxt    = 1'b1;
    w_oe_n_nxt    = 1'b1;
    w_we_n_nxt    = 1'b1;
    w_rom_oe_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!w_mreq_s) begin
          w_rom_cyc_nxt = r_rom_en && w_rom_hit;
          w_cnt_nxt     = WS;
          w_state_nxt   = (WS == 4'd0) ? ST_ACTIVE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (w_mreq_s) w_state_nxt = ST_RECOVER;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Strobes are registered from the state being entered, so they drop on the exit edge.
    if (w_state_nxt == ST_ACTIVE) begin
      if (w_rom_cyc_nxt) begin
        w_rom_oe_nxt = ~w_rd_s;
      end else begin
        w_ce_n_nxt = 1'b0;
        w_oe_n_nxt = w_rd_s;
        w_we_n_nxt = w_wr_s;
      end
    end

    if (r_state == ST_ACTIVE && !r_rom_cyc && !w_wr_s && a == LED_ADDR)
      w_led_nxt = d_in;

    // A concurrent memory cycle takes priority over the overlay-disable write.
    if (w_mreq_s && !w_iorq_s && !w_wr_s && m1_n && a[7:0] == ROMDIS_PORT)
      w_rom_en_nxt = 1'b0;
  end

  assign wait_n   = ~(~mreq_n && (WS != 4'd0) && !reset &&
                      (r_state == ST_IDLE || r_state == ST_WAIT));
  assign rom_addr = a[ROM_AW-1:0];
  assign rom_oe   = r_rom_oe;
  assign ce_n     = r_ce_n;
  assign oe_n     = r_oe_n;
  assign we_n     = r_we_n;
  assign led      = r_led;
  assign rom_en   = r_rom_en;

endmodule
